irq_ctrl: RTL

Interrupt controller that sits directly downstream of the timer peripherals. It collects their Interrupt outputs plus external device lines, latches and masks them, and prioritises them. It raises one registered request with a source id towards CP0, then tracks the handler through an ack/eret handshake. It is CPU-addressable through the same bridge-style register port as the timers.

---
 rtl/irq_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller placed after the timer peripherals. It latches and
//   masks the raw interrupt lines and picks the highest-priority source (the
//   lowest index wins). It then raises one registered request with a source id
//   towards CP0 and follows the handler through the ack/eret handshake.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   hw_int    raw interrupt lines (0 = timer0, 1 = timer1, others external)
//   data_in   bus write data
//   enabled   bus write enable for this device
//   addr      register select (bus address bits [3:2])
//   data_out  bus read data, combinational from addr
//   int_ack   one-cycle pulse from CP0 when the exception is taken
//   int_eret  one-cycle pulse from CP0 on eret
//   int_req   registered interrupt request to CP0
//   int_id    registered id of the highest-priority eligible source
//
// Register map
//   0 CTRL  [N_SRC-1:0] mask, [31] global IE
//   1 PEND  read pending, write-1-to-clear (edge-mode bits only)
//   2 MODE  [N_SRC-1:0] 1 = edge, 0 = level
//   3 STAT  [2:0] in-service id, [8] in-service valid, [18:16] int_id,
//           [24] int_req (read only)
//
// Build option
//   IRQ_INPUT_SYNC_EN : when defined, hw_int passes through a 2-flop
//   synchroniser before edge/level detection (adds 2 cycles of latency).
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  hw_int,
  input  logic [31:0]       data_in,
  input  logic              enabled,
  input  logic [1:0]        addr,
  output logic [31:0]       data_out,
  input  logic              int_ack,
  input  logic              int_eret,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [N_SRC-1:0] hw_s;

`ifdef IRQ_INPUT_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  end
  assign hw_s = sync2_q;
`else
  assign hw_s = hw_int;
`endif

  logic [N_SRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, prev_q, prev_d;
  logic             ie_q, ie_d;
  state_t           state_q, state_d;
  logic [ID_W-1:0]  isr_id_q, isr_id_d, int_id_q, int_id_d;
  logic             isr_valid_q, isr_valid_d, int_req_q, int_req_d;

  logic [N_SRC-1:0] eligible, rise, w1c, ack_clr;
  logic [ID_W-1:0]  winner;
  logic             wr_ctrl, wr_pend, wr_mode, ack_take;

  // Bits of the write bus that no register uses.
  logic unused_bits;
  assign unused_bits = ^data_in[30:N_SRC];

  assign wr_ctrl  = enabled && (addr == 2'd0);
  assign wr_pend  = enabled && (addr == 2'd1);
  assign wr_mode  = enabled && (addr == 2'd2);
  assign ack_take = (state_q == REQ) && int_ack;

  assign eligible = pend_q & mask_q & {N_SRC{ie_q}};
  assign rise     = hw_s & ~prev_q;
  assign w1c      = wr_pend ? data_in[N_SRC-1:0] : '0;

  // The acknowledged id clears its own edge pending bit.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ack_clr
    assign ack_clr[gi] = ack_take && (int_id_q == ID_W'(gi));
  end

  // Lowest set index wins: scan from the top so the lowest index overwrites.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    mask_d      = mask_q;
    ie_d        = ie_q;
    mode_d      = mode_q;
    prev_d      = hw_s;
    state_d     = state_q;
    isr_id_d    = isr_id_q;
    isr_valid_d = isr_valid_q;
    int_req_d   = int_req_q;
    int_id_d    = int_id_q;

    if (wr_ctrl) begin
      mask_d = data_in[N_SRC-1:0];
      ie_d   = data_in[31];
    end
    if (wr_mode) mode_d = data_in[N_SRC-1:0];

    // Edge bits: a rising edge beats a simultaneous clear.
    // Level bits: follow the line with one cycle of lag.
    pend_d = (mode_q & (rise | (pend_q & ~w1c & ~ack_clr))) | (~mode_q & hw_s);

    case (state_q)
      IDLE: begin
        int_req_d = 1'b0;
        if (eligible != '0) begin
          state_d   = REQ;
          int_req_d = 1'b1;
          int_id_d  = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          // ack takes precedence over a simultaneous eret or withdrawal
          state_d     = SERVICE;
          isr_id_d    = int_id_q;
          isr_valid_d = 1'b1;
          int_req_d   = 1'b0;
        end else if (eligible == '0) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end else begin
          int_req_d = 1'b1;
          int_id_d  = winner;
        end
      end
      SERVICE: begin
        int_req_d = 1'b0;
        if (int_eret) begin
          state_d     = IDLE;
          isr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q      <= '0;
      ie_q        <= 1'b0;
      mode_q      <= '0;
      pend_q      <= '0;
      prev_q      <= '0;
      state_q     <= IDLE;
      isr_id_q    <= '0;
      isr_valid_q <= 1'b0;
      int_req_q   <= 1'b0;
      int_id_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      ie_q        <= ie_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      isr_id_q    <= isr_id_d;
      isr_valid_q <= isr_valid_d;
      int_req_q   <= int_req_d;
      int_id_q    <= int_id_d;
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0: begin
        data_out[N_SRC-1:0] = mask_q;
        data_out[31]        = ie_q;
      end
      2'd1: data_out[N_SRC-1:0] = pend_q;
      2'd2: data_out[N_SRC-1:0] = mode_q;
      default: begin
        data_out[ID_W-1:0]  = isr_id_q;
        data_out[8]         = isr_valid_q;
        data_out[16+:ID_W]  = int_id_q;
        data_out[24]        = int_req_q;
      end
    endcase
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule
